// File: rtl/dac_tx_unpack.sv
// dac_tx_unpack: buffers 48-bit two-channel sample words and plays them out as 12-bit
// samples on channels A and B, one sample pair per DAC strobe.
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_i            synchronous active-low reset
//   wr_valid_i       input word valid
//   wr_data_i        input word {b1, b0, a1, a0}, 12 bits each
//   wr_ready_o       FIFO can accept a word
//   dac_strobe_i     one-cycle sample-rate tick
//   dac_data_a_o     channel A sample
//   dac_data_b_o     channel B sample
//   dac_valid_o      outputs carry real samples
//   level_o          FIFO occupancy in words
//   underflow_o      sticky underflow flag
//   clr_underflow_i  clears underflow_o (a new underflow in the same cycle wins)
module dac_tx_unpack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PRIME = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_valid_i,
  input  logic [47:0]              wr_data_i,
  output logic                     wr_ready_o,
  input  logic                     dac_strobe_i,
  output logic [11:0]              dac_data_a_o,
  output logic [11:0]              dac_data_b_o,
  output logic                     dac_valid_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     underflow_o,
  input  logic                     clr_underflow_i
);

  localparam int unsigned Aw = $clog2(DEPTH);
  localparam int unsigned Cw = Aw + 1;
  localparam logic [Cw-1:0] DepthLvl = Cw'(DEPTH);
  localparam logic [Cw-1:0] PrimeLvl = Cw'(PRIME);

  typedef enum logic [1:0] {StPrime, StLoSent, StHiSent} state_e;

  // Word storage; contents need no reset because the pointers define validity.
  logic [47:0]   mem_q [DEPTH];
  logic [Aw-1:0] wr_ptr_q, rd_ptr_q;
  logic [Cw-1:0] count_q;

  state_e        state_q, state_d;
  logic [23:0]   hold_q, hold_d;       // {b1, a1} of the word currently being played
  logic [11:0]   data_a_q, data_a_d;
  logic [11:0]   data_b_q, data_b_d;
  logic          valid_q, valid_d;
  logic          underflow_q, underflow_d;

  logic          push, pop, uf_set;
  logic [47:0]   rd_word;

  assign wr_ready_o = (count_q < DepthLvl);
  assign push       = wr_valid_i && wr_ready_o;
  assign rd_word    = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    valid_d  = valid_q;
    pop      = 1'b0;
    uf_set   = 1'b0;
    if (dac_strobe_i) begin
      unique case (state_q)
        StPrime: begin
          if (count_q >= PrimeLvl) begin
            pop      = 1'b1;
            data_a_d = rd_word[11:0];
            data_b_d = rd_word[35:24];
            hold_d   = {rd_word[47:36], rd_word[23:12]};
            valid_d  = 1'b1;
            state_d  = StLoSent;
          end
        end
        StLoSent: begin
          data_a_d = hold_q[11:0];
          data_b_d = hold_q[23:12];
          state_d  = StHiSent;
        end
        StHiSent: begin
          // Decision uses the registered level: a same-cycle push cannot rescue it.
          if (count_q != '0) begin
            pop      = 1'b1;
            data_a_d = rd_word[11:0];
            data_b_d = rd_word[35:24];
            hold_d   = {rd_word[47:36], rd_word[23:12]};
            state_d  = StLoSent;
          end else begin
            data_a_d = '0;
            data_b_d = '0;
            valid_d  = 1'b0;
            uf_set   = 1'b1;
            state_d  = StPrime;
          end
        end
        default: state_d = StPrime;
      endcase
    end
    if (uf_set) begin
      underflow_d = 1'b1;
    end else if (clr_underflow_i) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= StPrime;
      hold_q      <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + Aw'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + Aw'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + Cw'(1);
      end else if (pop && !push) begin
        count_q <= count_q - Cw'(1);
      end
      state_q     <= state_d;
      hold_q      <= hold_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      valid_q     <= valid_d;
      underflow_q <= underflow_d;
    end
  end

  assign dac_data_a_o = data_a_q;
  assign dac_data_b_o = data_b_q;
  assign dac_valid_o  = valid_q;
  assign level_o      = count_q;
  assign underflow_o  = underflow_q;

endmodule

// File: tb/tb_dac_tx_unpack.sv
module tb_dac_tx_unpack;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PRIME = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic [47:0] wr_data = '0;
  logic        wr_ready;
  logic        strobe = 1'b0;
  logic [11:0] dac_a, dac_b;
  logic        dac_valid;
  logic [3:0]  level;
  logic        underflow;
  logic        clr = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dac_tx_unpack #(.DEPTH(DEPTH), .PRIME(PRIME)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .wr_valid_i     (wr_valid),
    .wr_data_i      (wr_data),
    .wr_ready_o     (wr_ready),
    .dac_strobe_i   (strobe),
    .dac_data_a_o   (dac_a),
    .dac_data_b_o   (dac_b),
    .dac_valid_o    (dac_valid),
    .level_o        (level),
    .underflow_o    (underflow),
    .clr_underflow_i(clr)
  );

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word queue plus a queue of not-yet-played sample pairs.
  logic [47:0] mq[$];
  logic [23:0] pend[$];
  bit          priming;
  logic [11:0] ea, eb;
  bit          ev, euf, erdy, minit = 1'b0;
  int          elvl;

  always @(posedge clk) begin : model
    bit          push_m, ufset;
    int          need;
    logic [47:0] w;
    logic [23:0] s;
    if (!rst) begin
      mq.delete();
      pend.delete();
      priming = 1'b1;
      ea = '0; eb = '0; ev = 1'b0; euf = 1'b0;
      minit = 1'b1;
    end else begin
      push_m = wr_valid && (mq.size() < DEPTH);
      ufset  = 1'b0;
      if (strobe) begin
        if (pend.size() > 0) begin
          s  = pend.pop_front();
          ea = s[11:0];
          eb = s[23:12];
          ev = 1'b1;
        end else begin
          need = priming ? PRIME : 1;
          if (mq.size() >= need) begin
            w  = mq.pop_front();
            ea = w[11:0];
            eb = w[35:24];
            pend.push_back({w[47:36], w[23:12]});
            ev = 1'b1;
            priming = 1'b0;
          end else if (!priming) begin
            ea = '0; eb = '0; ev = 1'b0;
            ufset = 1'b1;
            priming = 1'b1;
          end
        end
      end
      if (ufset) euf = 1'b1;
      else if (clr) euf = 1'b0;
      if (push_m) mq.push_back(wr_data);
    end
    elvl = mq.size();
    erdy = (mq.size() < DEPTH);
  end

  always @(negedge clk) begin
    if (minit) begin
      check("data_a", 48'(dac_a), 48'(ea));
      check("data_b", 48'(dac_b), 48'(eb));
      check("valid", 48'(dac_valid), 48'(ev));
      check("level", 48'(level), 48'(elvl));
      check("wr_ready", 48'(wr_ready), 48'(erdy));
      check("underflow", 48'(underflow), 48'(euf));
    end
  end

  task automatic step(input logic v, input logic [47:0] d, input logic s, input logic c);
    wr_valid = v;
    wr_data  = d;
    strobe   = s;
    clr      = c;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    strobe   = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  function automatic logic [47:0] word(input int i);
    return {12'(12'h100 + 4 * i + 3), 12'(12'h100 + 4 * i + 2),
            12'(12'h100 + 4 * i + 1), 12'(12'h100 + 4 * i)};
  endfunction

  initial begin
    int idx;
    bit acc;

    // Reset then prime
    do_reset();
    check("rst_level", 48'(level), 48'd0);
    check("rst_ready", 48'(wr_ready), 48'd1);
    check("rst_valid", 48'(dac_valid), 48'd0);
    check("rst_uf", 48'(underflow), 48'd0);
    step(1'b1, 48'h444_333_222_111, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("prime_wait_valid", 48'(dac_valid), 48'd0);
    step(1'b1, 48'h888_777_666_555, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("s1", {24'(dac_b), 12'(dac_a), 11'd0, dac_valid}, {24'h333, 12'h111, 12'd1});
    step(1'b0, '0, 1'b1, 1'b0);
    check("s2", {24'(dac_b), 12'(dac_a), 11'd0, dac_valid}, {24'h444, 12'h222, 12'd1});
    step(1'b0, '0, 1'b1, 1'b0);
    check("s3", {24'(dac_b), 12'(dac_a), 11'd0, dac_valid}, {24'h777, 12'h555, 12'd1});
    step(1'b0, '0, 1'b1, 1'b0);
    check("s4", {24'(dac_b), 12'(dac_a), 11'd0, dac_valid}, {24'h888, 12'h666, 12'd1});

    // Full FIFO
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, word(i), 1'b0, 1'b0);
    check("full_level", 48'(level), 48'd8);
    check("full_ready", 48'(wr_ready), 48'd0);
    step(1'b1, word(8), 1'b0, 1'b0);
    check("full_hold_level", 48'(level), 48'd8);
    step(1'b0, '0, 1'b1, 1'b0);
    check("pop_level", 48'(level), 48'd7);
    check("pop_ready", 48'(wr_ready), 48'd1);
    check("pop_a", 48'(dac_a), 48'h100);
    for (int i = 0; i < 18; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Underflow and recovery
    do_reset();
    step(1'b1, 48'h444_333_222_111, 1'b0, 1'b0);
    step(1'b1, 48'h888_777_666_555, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("uf_valid", 48'(dac_valid), 48'd0);
    check("uf_a", 48'(dac_a), 48'd0);
    check("uf_flag", 48'(underflow), 48'd1);
    step(1'b1, 48'hCCC_BBB_AAA_999, 1'b0, 1'b0);
    step(1'b1, 48'h123_456_789_ABC, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("resume", {24'(dac_b), 12'(dac_a), 11'd0, dac_valid}, {24'hBBB, 12'h999, 12'd1});
    check("uf_sticky", 48'(underflow), 48'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("uf_clr", 48'(underflow), 48'd0);

    // Continuous streaming, strobe every cycle
    do_reset();
    idx = 0;
    for (int n = 0; n < 1000 && idx < 100; n++) begin
      acc = erdy;
      step(1'b1, word(idx), 1'b1, 1'b0);
      if (acc) idx++;
    end
    check("stream_count", 48'(idx), 48'd100);
    check("stream_no_uf", 48'(underflow), 48'd0);

    // Push and pop in the same cycle at level 3, across pointer wrap
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, word(20 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, word(23), 1'b1, 1'b0);
    check("pp_start", 48'(level), 48'd3);
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) step(1'b1, word(24 + k), 1'b1, 1'b0);
      else step(1'b0, '0, 1'b1, 1'b0);
      check("pp_level", 48'(level), 48'd3);
    end
    step(1'b1, word(40), 1'b1, 1'b0);

    // Reset mid-playout (state LO_SENT)
    do_reset();
    check("mid_rst", {24'(dac_b), 12'(dac_a), 4'(level), 7'd0, dac_valid}, 48'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("mid_valid", 48'(dac_valid), 48'd0);
    check("mid_uf", 48'(underflow), 48'd0);

    step(1'b0, '0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_tx_unpack.md
Name: dac_tx_unpack

Overview:
- Transmit-side counterpart of the ADC capture FIFOs: accepts 48-bit two-channel sample words from the system logic and plays them out as 12-bit samples on channels A and B.
- Output rate is set by a DAC sample-rate strobe.
- Contains a small word FIFO, a prime/run/underflow state machine and a two-phase lane unpacker.
- Single clock domain (system clock); the DAC-side clock crossing is outside this block.

Parameters:
- DEPTH, 8, word FIFO depth in 48-bit words; power of two, at least 2.
- PRIME, 2, FIFO level required before playout starts or restarts; 1 ≤ PRIME ≤ DEPTH.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- wr_valid_i  input  1  input word valid.
- wr_data_i  input  48  input word: {b1[47:36], b0[35:24], a1[23:12], a0[11:0]}.
- wr_ready_o  output  1  FIFO can accept a word.
- dac_strobe_i  input  1  one-cycle sample-rate tick.
- dac_data_a_o  output  12  channel A sample.
- dac_data_b_o  output  12  channel B sample.
- dac_valid_o  output  1  current outputs are real samples.
- level_o  output  $clog2(DEPTH)+1  current FIFO occupancy in words.
- underflow_o  output  1  sticky underflow flag.
- clr_underflow_i  input  1  clears underflow_o.

Behaviour:
- Reset: on rst_i=0 at a clock edge:
  - FIFO emptied, level_o=0, wr_ready_o=1.
  - dac_data_a_o=0, dac_data_b_o=0, dac_valid_o=0, underflow_o=0.
  - State = S_PRIME.
- Write side:
  - A word is pushed when wr_valid_i && wr_ready_o.
  - wr_ready_o = (level < DEPTH), taken from the registered count. No push is accepted while full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo DEPTH.
- State machine (advances only on cycles with dac_strobe_i=1):
  - S_PRIME: outputs 0, dac_valid_o=0. On a strobe with level ≥ PRIME: pop word W, drive a0/b0, dac_valid_o=1, go to S_LO_SENT. Otherwise stay.
  - S_LO_SENT: on strobe, drive a1/b1 from the held W, go to S_HI_SENT. The FIFO is not touched.
  - S_HI_SENT, FIFO non-empty on strobe: pop the next word, drive its a0/b0, go to S_LO_SENT.
  - S_HI_SENT, FIFO empty on strobe (underflow):
    - Outputs forced to 0, dac_valid_o=0, underflow_o set to 1.
    - Go to S_PRIME; playout restarts only after the FIFO re-reaches PRIME.
- Pop/push interaction: the pop looks at the registered level. A word pushed in the same cycle as an empty-check does not prevent underflow (no bypass).
- Latency:
  - Outputs update on the clock edge that samples the strobe, i.e. visible the cycle after dac_strobe_i=1.
  - Minimum write-to-output latency: one cycle for the push, plus the next strobe.
  - Outputs hold their values between strobes.
- Sample order per word: A and B channels change together: (a0,b0), then (a1,b1).
- Underflow flag:
  - Sticky.
  - clr_underflow_i=1 clears it on the next edge.
  - If set and clear occur in the same cycle, set wins.
- Strobe spacing: back-to-back strobes (every cycle) must be supported. With no strobes, no state change.
- Reset mid-playout: immediate return to the reset values above; any held word and FIFO contents are discarded.

Test Plan:
- Reset then prime: write 0x444_333_222_111 and 0x888_777_666_555 (PRIME=2), then 4 strobes -> A/B outputs (0x111,0x333), (0x222,0x444), (0x555,0x777), (0x666,0x888), dac_valid_o=1 throughout. Before the 2nd write, strobes leave valid=0.
- Full: push 9 words with DEPTH=8 and no strobes -> wr_ready_o=0 after the 8th, level_o=8, 9th word held off. One strobe (pop) -> level 7 and wr_ready_o=1 the next cycle.
- Underflow: prime with 2 words, issue 5 strobes -> 5th strobe gives outputs 0, dac_valid_o=0, underflow_o=1, state S_PRIME. Write 2 more words -> playout resumes with their a0/b0. Assert clr_underflow_i -> underflow_o=0.
- Strobe every cycle with continuous writes, 100 words of incrementing data -> outputs exactly in order, no underflow, level never exceeds DEPTH.
- Push and pop in the same cycle at level 3 -> level stays 3, data order preserved across pointer wrap (more than 8 pushes total).
- Mid-playout: assert rst_i=0 for one cycle during S_LO_SENT -> next cycle all outputs 0, level_o=0. A subsequent strobe with no writes leaves valid=0 and underflow_o=0.
